// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory-cache port: IDLE -> ISSUE -> WAIT -> RESP.
// Optional round-robin tie-breaking via `define MEM_ARB_RR_EN; default build gives data fixed priority.
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [15:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_be,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        d_err,
  output logic        mc_ce,
  output logic        mc_rw_req,
  output logic        mc_rw,
  output logic [31:0] mc_address,
  output logic [1:0]  mc_be,
  output logic [15:0] mc_write_data,
  input  logic [15:0] mc_read_data,
  input  logic        mc_data_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state;
  logic [7:0]  timer;
  logic        grant_d;
  logic [31:0] lat_addr;
  logic [1:0]  lat_be;
  logic        lat_rw;
  logic [15:0] lat_wdata;
  logic        win_d;

`ifdef MEM_ARB_RR_EN
  logic last_d;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    win_d = d_req && (!i_req || !last_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_d <= 1'b1;
    end else if (state == IDLE && (i_req || d_req)) begin
      last_d <= win_d;
    end
  end
`else
  always_comb begin
    win_d = d_req;
  end
`endif

  assign mc_address    = lat_addr;
  assign mc_be         = lat_be;
  assign mc_rw         = lat_rw;
  assign mc_write_data = lat_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= 8'd0;
      grant_d   <= 1'b0;
      lat_addr  <= 32'd0;
      lat_be    <= 2'b00;
      lat_rw    <= 1'b0;
      lat_wdata <= 16'd0;
      mc_ce     <= 1'b0;
      mc_rw_req <= 1'b0;
      i_ack     <= 1'b0;
      i_err     <= 1'b0;
      i_rdata   <= 16'd0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= 16'd0;
    end else begin
      i_ack     <= 1'b0;
      i_err     <= 1'b0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      mc_rw_req <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            grant_d <= win_d;
            if (win_d) begin
              lat_addr  <= d_addr;
              lat_be    <= d_be;
              lat_rw    <= d_rw;
              lat_wdata <= d_wdata;
            end else begin
              lat_addr  <= i_addr;
              lat_be    <= 2'b11;
              lat_rw    <= 1'b0;
              lat_wdata <= 16'd0;
            end
            mc_ce     <= 1'b1;
            mc_rw_req <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= 8'd0;
          state <= WAIT;
        end
        WAIT: begin
          // Valid takes precedence over a timeout landing in the same cycle.
          if (mc_data_valid) begin
            if (grant_d) begin
              d_rdata <= mc_read_data;
              d_ack   <= 1'b1;
            end else begin
              i_rdata <= mc_read_data;
              i_ack   <= 1'b1;
            end
            mc_ce <= 1'b0;
            state <= RESP;
          end else if (timer == 8'(TIMEOUT - 1)) begin
            if (grant_d) begin
              d_ack <= 1'b1;
              d_err <= 1'b1;
            end else begin
              i_ack <= 1'b1;
              i_err <= 1'b1;
            end
            mc_ce <= 1'b0;
            state <= RESP;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
